timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares one W-bit elapsed-cycle counter (the timer resource) among NREQ requesters.
- Each requester asks for a delay of its own length. The block grants the timer round-robin, runs the count, and returns a one-cycle done pulse to the winner.
- Sits between timer_parameter-style client logic and the single shared timer, so each client does not need its own counter.

Parameters:
- NREQ, 4, number of requesters (>=2).
- W, 16, duration/counter width in bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; req[i] is held high until done[i] or until the requester aborts.
- dur  input  NREQ*W  per-requester duration; slice i = dur[i*W +: W]; sampled only on the grant edge.
- grant  output  NREQ  one-hot or zero; grant[i]=1 while requester i owns the timer.
- done  output  NREQ  one-hot or zero, one-cycle pulse; the owner's duration has elapsed.
- busy  output  1  high in RUN and DONE states.
- count  output  W  elapsed cycles of the current grant; 0 when idle.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: grant=0, done=0, busy=0, count=0.
  - State=IDLE; round-robin pointer=NREQ-1, so index 0 has highest priority first.
  - All outputs are registered.
- IDLE:
  - If req!=0, select the first asserted index searching upward from pointer+1, with modulo-NREQ wrap.
  - Next edge: grant[winner]=1, count=0, latch dur slice into dur_q, pointer=winner, state=RUN.
  - If req=0, stay in IDLE.
- RUN:
  - Abort: if req[owner]=0 on an edge, next state=IDLE, grant=0, count=0, no done. Abort takes priority over expiry on the same edge.
  - Expiry: else if count==dur_q, next state=DONE, grant=0, done[owner]=1, count=0.
  - Otherwise count increments by 1.
- DONE:
  - Lasts exactly one cycle; done pulse is high.
  - No arbitration in this cycle. The requester must drop req in this cycle to avoid re-request, and any still-high req is considered in the next IDLE cycle.
  - Next state=IDLE, done=0.
- Latency for a request with dur=D, req sampled at edge 0:
  - grant high cycles 1..D+1 (D+1 cycles).
  - done high cycle D+2.
  - Earliest next grant: cycle D+4 (DONE -> IDLE -> grant).
- Arithmetic and boundaries:
  - dur=0: grant for 1 cycle, then done.
  - dur=2^W-1: count reaches all-ones exactly, never wraps.
  - Changes to dur after the grant edge are ignored.
  - req from non-owners during RUN/DONE is ignored, never lost; it is re-evaluated in IDLE.
- Fairness: the pointer updates on every grant, including aborted ones. A continuously requesting client waits at most NREQ-1 other grants.
- Reset mid-operation clears everything immediately. After release the block is in IDLE with index 0 highest priority, and there is no done for the interrupted grant.

Test Plan:
1. Single request: after reset, req[0]=1, dur0=5 at edge 0 -> grant=4'b0001 cycles 1-6, count 0..5, done=4'b0001 at cycle 7 only, busy cycles 1-7.
2. Simultaneous requests: req=4'b1111, all dur=2, each requester dropping req on its done -> grant order 0,1,2,3. Each grant lasts 3 cycles; grants start 5 cycles apart.
3. Round-robin fairness: req[0] and req[2] re-asserted immediately after each done, dur=1 -> grant sequence 0,2,0,2,0,2; index 1 and 3 never granted.
4. Boundary durations:
   - dur1=0 -> grant[1] exactly 1 cycle, done[1] next cycle.
   - dur3=16'hFFFF -> done[3] after 65536 grant cycles with count never wrapping.
5. Abort: req[1], dur1=100, with req[2] pending; drop req[1] when count=10 -> grant=0 next edge, no done[1] ever, grant[2] one cycle later.
6. Async reset mid-run: reset_n=0 at count=50 of req[2] grant, between edges -> grant/done/busy/count=0 immediately. After release with req=4'b0101 -> index 0 granted first.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one W-bit elapsed-cycle timer among NREQ requesters.
// The winner holds grant for dur+1 cycles, then receives a one-cycle done pulse.
module timer_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dur,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [W-1:0]      count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [W-1:0]    count_q;
  logic [W-1:0]    dur_q;

  logic            found_d;
  logic [IW-1:0]   winner_d;
  logic [IW-1:0]   cand_d;
  logic [NREQ-1:0] grant_d;
  logic [W-1:0]    dur_d;

  // Search upward from ptr_q+1 with wrap, so the last owner has lowest priority.
  always_comb begin
    found_d  = 1'b0;
    winner_d = ptr_q;
    cand_d   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_d = IW'((32'(ptr_q) + k) % NREQ);
      if (!found_d && req[cand_d]) begin
        found_d  = 1'b1;
        winner_d = cand_d;
      end
    end
  end

  always_comb begin
    grant_d = '0;
    dur_d   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner_d == IW'(i)) begin
        grant_d[i] = 1'b1;
        dur_d      = dur[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      dur_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (found_d) begin
            state_q <= S_RUN;
            ptr_q   <= winner_d;
            grant_q <= grant_d;
            dur_q   <= dur_d;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // Abort wins over expiry when both happen on the same edge.
          if (!req[ptr_q]) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (count_q == dur_q) begin
            state_q <= S_DONE;
            grant_q <= '0;
            done_q  <= grant_q;
            count_q <= '0;
          end else begin
            count_q <= count_q + W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: single grant, round-robin order, fairness,
// boundary durations, abort and asynchronous reset mid-run.
module tb_timer_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] dur = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      count;

  int unsigned npass  = 0;
  int unsigned ntotal = 0;

  timer_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .dur     (dur),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    dur     = '0;
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_count", 64'(count), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int unsigned bad;
    int unsigned exp_idx;

    // 1. single request, dur0=5
    do_reset();
    dur[0*W +: W] = 16'd5;
    req = 4'b0001;
    tick();
    for (int c = 1; c <= 6; c++) begin
      chk("t1_grant", 64'(grant), 64'(4'b0001));
      chk("t1_count", 64'(count), 64'(c - 1));
      chk("t1_busy",  64'(busy),  64'(1));
      chk("t1_nodone", 64'(done), 64'(0));
      tick();
    end
    chk("t1_done",      64'(done),  64'(4'b0001));
    chk("t1_done_gnt",  64'(grant), 64'(0));
    chk("t1_done_busy", 64'(busy),  64'(1));
    chk("t1_done_cnt",  64'(count), 64'(0));
    req = '0;
    tick();
    chk("t1_idle_done", 64'(done), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));

    // 2. all request, dur=2, order 0,1,2,3, starts 5 cycles apart
    do_reset();
    for (int i = 0; i < 4; i++) dur[i*W +: W] = 16'd2;
    req = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        chk("t2_grant", 64'(grant), 64'(1 << i));
        chk("t2_count", 64'(count), 64'(c));
        tick();
      end
      chk("t2_done", 64'(done),  64'(1 << i));
      chk("t2_dgnt", 64'(grant), 64'(0));
      req[i] = 1'b0;
      tick();
      chk("t2_idle", 64'(grant), 64'(0));
      tick();
    end
    chk("t2_end_busy", 64'(busy), 64'(0));

    // 3. fairness between 0 and 2, dur=1
    do_reset();
    dur[0*W +: W] = 16'd1;
    dur[2*W +: W] = 16'd1;
    req = 4'b0101;
    tick();
    for (int g = 0; g < 6; g++) begin
      exp_idx = (g % 2 == 1) ? 2 : 0;
      for (int c = 0; c < 2; c++) begin
        chk("t3_grant", 64'(grant), 64'(1 << exp_idx));
        tick();
      end
      chk("t3_done", 64'(done), 64'(1 << exp_idx));
      req[exp_idx] = 1'b0;
      tick();
      chk("t3_idle", 64'(grant), 64'(0));
      req[exp_idx] = 1'b1;
      tick();
    end
    req = '0;

    // 4a. dur1=0: one grant cycle then done
    do_reset();
    dur[1*W +: W] = 16'd0;
    req = 4'b0010;
    tick();
    chk("t4_g1",   64'(grant), 64'(4'b0010));
    chk("t4_c1",   64'(count), 64'(0));
    tick();
    chk("t4_g1off", 64'(grant), 64'(0));
    chk("t4_d1",    64'(done),  64'(4'b0010));
    req = '0;
    tick();
    chk("t4_d1off", 64'(done), 64'(0));

    // 4b. dur3=FFFF, with dur changed after the grant edge
    dur[3*W +: W] = 16'hFFFF;
    req = 4'b1000;
    tick();
    dur[3*W +: W] = 16'd5;
    bad = 0;
    for (int c = 0; c < 65536; c++) begin
      if (count !== c[15:0] || grant !== 4'b1000 || done !== 4'b0000) bad++;
      tick();
    end
    chk("t4_long_run", 64'(bad), 64'(0));
    chk("t4_d3",       64'(done),  64'(4'b1000));
    chk("t4_d3_cnt",   64'(count), 64'(0));
    chk("t4_d3_gnt",   64'(grant), 64'(0));
    req = '0;
    tick();

    // 5. abort of requester 1 at count=10 with requester 2 pending
    do_reset();
    dur[1*W +: W] = 16'd100;
    dur[2*W +: W] = 16'd3;
    req = 4'b0110;
    tick();
    chk("t5_g1", 64'(grant), 64'(4'b0010));
    for (int c = 0; c < 10; c++) tick();
    chk("t5_c10", 64'(count), 64'(10));
    req[1] = 1'b0;
    tick();
    chk("t5_ab_gnt",  64'(grant), 64'(0));
    chk("t5_ab_done", 64'(done),  64'(0));
    chk("t5_ab_busy", 64'(busy),  64'(0));
    chk("t5_ab_cnt",  64'(count), 64'(0));
    tick();
    chk("t5_g2",      64'(grant), 64'(4'b0100));
    chk("t5_g2_done", 64'(done),  64'(0));

    // 6. async reset at count=50 of requester 2
    do_reset();
    dur[2*W +: W] = 16'd100;
    req = 4'b0100;
    tick();
    for (int c = 0; c < 50; c++) tick();
    chk("t6_c50", 64'(count), 64'(50));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_r_gnt",  64'(grant), 64'(0));
    chk("t6_r_done", 64'(done),  64'(0));
    chk("t6_r_busy", 64'(busy),  64'(0));
    chk("t6_r_cnt",  64'(count), 64'(0));
    req = 4'b0101;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t6_g0",   64'(grant), 64'(4'b0001));
    chk("t6_nodn", 64'(done),  64'(0));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
